// File: rtl/prbs_lock_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_lock_checker
//  Description : Serial PRBS checker. Self-seeds a local Fibonacci LFSR from
//                the incoming stream, qualifies lock over a run of matching
//                bits, then counts mismatches against the predicted sequence
//                and drops lock when too many errors land in one window.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous, active-low reset
//                data_in    - serial data bit
//                data_valid - data_in qualifier; nothing advances while low
//                clear_cnt  - synchronous clear of err_count
//                locked     - 1 while in LOCKED
//                err_pulse  - one-cycle pulse per mismatch seen in LOCKED
//                err_count  - saturating mismatch count (LOCKED only)
//                state_o    - FSM state: 0=SEED 1=VERIFY 2=LOCKED
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_lock_checker #(
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] POLY       = 16'h801C,
    parameter int                    LOCK_CNT   = 32,
    parameter int                    WINDOW     = 256,
    parameter int                    ERR_THRESH = 4,
    parameter int                    CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam int c_SEED_W  = $clog2(LFSR_WIDTH);
    localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W   = $clog2(WINDOW);
    localparam int c_WERR_W  = $clog2(ERR_THRESH + 1);

    localparam logic [c_SEED_W-1:0]  c_SEED_LAST  = c_SEED_W'(LFSR_WIDTH - 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
    localparam logic [c_WIN_W-1:0]   c_WIN_LAST   = c_WIN_W'(WINDOW - 1);
    localparam logic [c_WERR_W-1:0]  c_THRESH     = c_WERR_W'(ERR_THRESH);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                r_state;
    logic [LFSR_WIDTH-1:0] r_shreg;
    logic [c_SEED_W-1:0]   r_seed_cnt;
    logic [c_MATCH_W-1:0]  r_match_cnt;
    logic [c_WIN_W-1:0]    r_win_cnt;
    logic [c_WERR_W-1:0]   r_win_err;
    logic                  r_locked;
    logic                  r_err_pulse;
    logic [CNT_W-1:0]      r_err_count;

    logic                  w_pred;
    logic                  w_match;
    logic                  w_mis;
    logic                  w_win_wrap;
    logic [c_WERR_W-1:0]   w_win_err_base;
    logic [c_WERR_W-1:0]   w_win_err_nxt;
    logic                  w_thresh_hit;
    logic                  w_cnt_max;

    // shreg[0] is the newest bit, so tap k looks k+1 bits back in the stream.
    assign w_pred  = ^(r_shreg & POLY);
    assign w_match = (data_in == w_pred);

    // A mismatch only counts as an error once the checker is locked.
    assign w_mis = data_valid && (r_state == ST_LOCKED) && !w_match;

    // The wrap bit opens a fresh window, and its own mismatch belongs to it.
    assign w_win_wrap     = (r_win_cnt == c_WIN_LAST);
    assign w_win_err_base = w_win_wrap ? '0 : r_win_err;
    assign w_win_err_nxt  = w_win_err_base + c_WERR_W'(w_mis);
    assign w_thresh_hit   = (w_win_err_nxt == c_THRESH);

    assign w_cnt_max = &r_err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SEED;
            r_shreg     <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_mis;

            // A clear coinciding with a counted error leaves that error counted.
            if (clear_cnt) begin
                r_err_count <= w_mis ? CNT_W'(1) : '0;
            end else if (w_mis && !w_cnt_max) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end

            if (data_valid) begin
                case (r_state)
                    ST_SEED: begin
                        r_shreg <= {r_shreg[LFSR_WIDTH-2:0], data_in};
                        if (r_seed_cnt == c_SEED_LAST) begin
                            r_state     <= ST_VERIFY;
                            r_seed_cnt  <= '0;
                            r_match_cnt <= '0;
                        end else begin
                            r_seed_cnt <= r_seed_cnt + c_SEED_W'(1);
                        end
                    end

                    ST_VERIFY: begin
                        r_shreg <= {r_shreg[LFSR_WIDTH-2:0], data_in};
                        if (w_match) begin
                            if (r_match_cnt == c_MATCH_LAST) begin
                                r_state   <= ST_LOCKED;
                                r_locked  <= 1'b1;
                                r_win_cnt <= '0;
                                r_win_err <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + c_MATCH_W'(1);
                            end
                        end else begin
                            r_state    <= ST_SEED;
                            r_seed_cnt <= '0;
                        end
                    end

                    ST_LOCKED: begin
                        // Flywheel: keep running on our own prediction so an
                        // isolated bad bit cannot poison later predictions.
                        r_shreg   <= {r_shreg[LFSR_WIDTH-2:0], w_pred};
                        r_win_cnt <= w_win_wrap ? '0 : r_win_cnt + c_WIN_W'(1);
                        r_win_err <= w_win_err_nxt;
                        if (w_thresh_hit) begin
                            r_state    <= ST_SEED;
                            r_locked   <= 1'b0;
                            r_seed_cnt <= '0;
                        end
                    end

                    default: begin
                        r_state    <= ST_SEED;
                        r_locked   <= 1'b0;
                        r_seed_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign state_o   = r_state;

endmodule
`default_nettype wire
